// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: run/step/halt FSM plus load-use and ID control-transfer hazard steering.
// Optional stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_BITS = 5,
  parameter int CNT_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_dbg_run,
  input  logic                i_dbg_step,
  input  logic                i_dbg_stop,
  input  logic [REG_BITS-1:0] ID_rs,
  input  logic [REG_BITS-1:0] ID_rt,
  input  logic                ID_uses_rt,
  input  logic                EX_mem_read,
  input  logic [REG_BITS-1:0] EX_rt,
  input  logic                ID_branch_taken,
  input  logic                ID_jump,
  input  logic                WB_halt,
  output logic                o_pipe_en,
  output logic                o_pc_write,
  output logic                o_IF_ID_write,
  output logic                o_IF_ID_flush,
  output logic                o_ID_EX_flush,
  output logic [1:0]          o_state,
  output logic [CNT_W-1:0]    o_stall_cnt,
  output logic [CNT_W-1:0]    o_flush_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   loadUse;
  logic   xfer;

  // A STEP lasts exactly one cycle; HALTED is only left through reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_dbg_stop)      state_d = IDLE;
        else if (i_dbg_step) state_d = STEP;
        else if (i_dbg_run)  state_d = RUN;
      end
      RUN: begin
        if (WB_halt)         state_d = HALTED;
        else if (i_dbg_stop) state_d = IDLE;
      end
      STEP:    state_d = WB_halt ? HALTED : IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign loadUse = EX_mem_read && (EX_rt != '0) &&
                   ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
  assign xfer    = ID_branch_taken || ID_jump;

  // A load-use stall freezes PC and IF/ID and suppresses the transfer flush;
  // the branch in ID re-resolves once the load has moved on.
  always_comb begin
    o_pipe_en     = (state_q == RUN) || (state_q == STEP);
    o_pc_write    = o_pipe_en && !loadUse;
    o_IF_ID_write = o_pipe_en && !loadUse;
    o_IF_ID_flush = o_pipe_en && !loadUse && xfer;
    o_ID_EX_flush = o_pipe_en && loadUse;
  end

  assign o_state = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  // Saturating counters; they stop at all-ones rather than wrapping.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (o_pipe_en && loadUse && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + 1'b1;
    if (o_IF_ID_flush && (flushCnt_q != '1))        flushCnt_d = flushCnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign o_stall_cnt = stallCnt_q;
  assign o_flush_cnt = flushCnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl, checked against a behavioural model.
// Counter expectations follow PIPE_PERF_CNT_EN; the DUT is built with a 4-bit counter width.
module tb_pipe_hazard_ctrl;

  localparam int RB = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          run, step, stop;
  logic [RB-1:0] idRs, idRt, exRt;
  logic          usesRt, memRead, brTaken, jump, wbHalt;

  logic          pipeEn, pcWrite, ifIdWrite, ifIdFlush, idExFlush;
  logic [1:0]    state;
  logic [CW-1:0] stallCnt, flushCnt;

  int vectors    = 0;
  int miscompares = 0;

  // model: mode 0 idle, 1 running, 2 single-stepping, 3 halted
  int mode;
  int mStall, mFlush;

  pipe_hazard_ctrl #(.REG_BITS(RB), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_dbg_run(run), .i_dbg_step(step), .i_dbg_stop(stop),
    .ID_rs(idRs), .ID_rt(idRt), .ID_uses_rt(usesRt),
    .EX_mem_read(memRead), .EX_rt(exRt),
    .ID_branch_taken(brTaken), .ID_jump(jump), .WB_halt(wbHalt),
    .o_pipe_en(pipeEn), .o_pc_write(pcWrite), .o_IF_ID_write(ifIdWrite),
    .o_IF_ID_flush(ifIdFlush), .o_ID_EX_flush(idExFlush), .o_state(state),
    .o_stall_cnt(stallCnt), .o_flush_cnt(flushCnt)
  );

  always #5 clk = ~clk;

  function automatic bit modelLoadUse();
    if (!memRead || exRt == 0) return 1'b0;
    return (exRt == idRs) || (usesRt && exRt == idRt);
  endfunction

  function automatic int satVal(int n);
`ifdef PIPE_PERF_CNT_EN
    return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected controls: {pipe_en, pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush}
  task automatic checkOutput();
    bit        active;
    bit        lu;
    logic [4:0] exp;
    active = (mode == 1) || (mode == 2);
    lu     = modelLoadUse();
    if (!active)               exp = 5'b00000;
    else if (lu)               exp = 5'b10001;
    else if (brTaken || jump)  exp = 5'b11110;
    else                       exp = 5'b11100;
    check("state", 32'(state), 32'(mode));
    check("ctrl", 32'({pipeEn, pcWrite, ifIdWrite, ifIdFlush, idExFlush}), 32'(exp));
    check("stall_cnt", 32'(stallCnt), 32'(satVal(mStall)));
    check("flush_cnt", 32'(flushCnt), 32'(satVal(mFlush)));
  endtask

  task automatic advanceModel();
    bit active;
    active = (mode == 1) || (mode == 2);
    if (active && modelLoadUse()) mStall++;
    else if (active && (brTaken || jump)) mFlush++;
    case (mode)
      0: mode = stop ? 0 : step ? 2 : run ? 1 : 0;
      1: mode = wbHalt ? 3 : stop ? 0 : 1;
      2: mode = wbHalt ? 3 : 0;
      default: mode = 3;
    endcase
  endtask

  // Called at a falling edge with the stimulus variables already set.
  task automatic applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    advanceModel();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    {run, step, stop, usesRt, memRead, brTaken, jump, wbHalt} = '0;
    idRs = '0; idRt = '0; exRt = '0;
  endtask

  // Reset asserted in the middle of the low phase must act without a clock edge.
  task automatic asyncReset();
    #2 rst = 1'b1;
    #1;
    mode = 0; mStall = 0; mFlush = 0;
    check("rst_async_state", 32'(state), 32'd0);
    check("rst_async_ctrl", 32'({pipeEn, pcWrite, ifIdWrite, ifIdFlush, idExFlush}), 32'd0);
    check("rst_async_cnt", 32'({stallCnt, flushCnt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit [3:0] pat;
    int       haltedFor;
    clearInputs();
    rst = 1'b1;
    mode = 0; mStall = 0; mFlush = 0;
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'({pipeEn, pcWrite, ifIdWrite, ifIdFlush, idExFlush}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] run pulse");
    run = 1'b1; applyStimulus(); run = 1'b0;
    applyStimulus();
    check("run_entered", 32'({state, pipeEn, pcWrite, ifIdFlush, idExFlush}), 32'b01_1100);

    $display("[TB] load-use and register zero");
    memRead = 1'b1; exRt = 5'd5; idRs = 5'd5; applyStimulus();
    idRs = 5'd7; idRt = 5'd5; usesRt = 1'b0; applyStimulus();
    usesRt = 1'b1; applyStimulus();
    exRt = 5'd0; idRs = 5'd0; idRt = 5'd0; applyStimulus();
    clearInputs();

    $display("[TB] branch under load-use");
    memRead = 1'b1; exRt = 5'd9; idRt = 5'd9; usesRt = 1'b1; brTaken = 1'b1; applyStimulus();
    memRead = 1'b0; applyStimulus();
    brTaken = 1'b0; jump = 1'b1; applyStimulus();
    clearInputs();

    $display("[TB] stop, then held step");
    stop = 1'b1; applyStimulus(); stop = 1'b0;
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 pat[3 - i] = pipeEn;
      #0 applyStimulus();
    end
    step = 1'b0;
    check("step_pattern", 32'(pat), 32'b0101);
    {run, step, stop} = 3'b111; applyStimulus();
    {run, step, stop} = 3'b000; applyStimulus();
    check("all_cmds_idle", 32'(state), 32'd0);

    $display("[TB] halt beats stop");
    run = 1'b1; applyStimulus(); run = 1'b0;
    wbHalt = 1'b1; stop = 1'b1; applyStimulus();
    clearInputs();
    run = 1'b1; step = 1'b1; applyStimulus();
    clearInputs(); applyStimulus();
    check("halted_sticky", 32'({state, pipeEn}), 32'b110);
    asyncReset();

    $display("[TB] counter saturation");
    run = 1'b1; applyStimulus(); run = 1'b0;
    memRead = 1'b1; exRt = 5'd3; idRs = 5'd3;
    for (int i = 0; i < 20; i++) applyStimulus();
    clearInputs(); applyStimulus();
`ifdef PIPE_PERF_CNT_EN
    check("stall_saturated", 32'(stallCnt), 32'd15);
`else
    check("stall_absent", 32'(stallCnt), 32'd0);
`endif
    memRead = 1'b1; exRt = 5'd3; idRs = 5'd3;
    applyStimulus();
    asyncReset();

    $display("[TB] randomized phase");
    haltedFor = 0;
    for (int i = 0; i < 600; i++) begin
      run     = ($urandom_range(0, 7) == 0);
      step    = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 11) == 0);
      wbHalt  = ($urandom_range(0, 39) == 0);
      memRead = $urandom_range(0, 1);
      usesRt  = $urandom_range(0, 1);
      exRt    = RB'($urandom_range(0, 3));
      idRs    = RB'($urandom_range(0, 3));
      idRt    = RB'($urandom_range(0, 3));
      brTaken = ($urandom_range(0, 3) == 0);
      jump    = ($urandom_range(0, 5) == 0);
      if (mode == 3) haltedFor++;
      if (haltedFor > 6) begin
        haltedFor = 0;
        asyncReset();
      end else begin
        applyStimulus();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
